// File: rtl/rvga_membus_arbiter.sv
// Two-to-one round-robin arbiter sharing one memory port between the
// instruction-side and data-side buses, with optional response timeout.
module rvga_membus_arbiter #(
   parameter int addr_width     = 32,
   parameter int data_width     = 32,
   parameter int timeout_cycles = 0
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [addr_width-1:0] i_addr_i,
   input  logic                  i_read_i,
   output logic [data_width-1:0] i_rdata_o,
   output logic                  i_resp_o,
   input  logic [addr_width-1:0] d_addr_i,
   input  logic                  d_read_i,
   input  logic                  d_write_i,
   input  logic [data_width-1:0] d_wdata_i,
   output logic [data_width-1:0] d_rdata_o,
   output logic                  d_resp_o,
   output logic [addr_width-1:0] mem_addr_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic [data_width-1:0] mem_wdata_o,
   input  logic [data_width-1:0] mem_rdata_i,
   input  logic                  mem_resp_i,
   output logic                  timeout_err_o
);

   localparam int CW = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);

   typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

   state_t          r_state, w_next;
   logic            r_last_d;
   logic [CW-1:0]   r_cnt;
   logic            r_err;
   logic            w_req_i, w_req_d, w_tmo, w_done;

   assign w_req_i = i_read_i;
   assign w_req_d = d_read_i | d_write_i;

   // A real response in the same cycle as the limit takes precedence.
   assign w_tmo  = (timeout_cycles > 0) && (r_state != IDLE) && !mem_resp_i &&
                   (r_cnt == CW'(timeout_cycles));
   assign w_done = (r_state != IDLE) && (mem_resp_i || w_tmo);

   assign i_rdata_o     = mem_rdata_i;
   assign d_rdata_o     = mem_rdata_i;
   assign timeout_err_o = r_err;

   always_comb begin
      w_next      = r_state;
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_read_o  = 1'b0;
      mem_write_o = 1'b0;
      i_resp_o    = 1'b0;
      d_resp_o    = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_req_i && w_req_d) w_next = r_last_d ? GNT_I : GNT_D;
            else if (w_req_i)       w_next = GNT_I;
            else if (w_req_d)       w_next = GNT_D;
         end
         GNT_I: begin
            mem_addr_o = i_addr_i;
            mem_read_o = 1'b1;
            i_resp_o   = mem_resp_i || w_tmo;
            if (w_done) w_next = IDLE;
         end
         GNT_D: begin
            mem_addr_o  = d_addr_i;
            mem_wdata_o = d_wdata_i;
            mem_write_o = d_write_i;
            mem_read_o  = !d_write_i;
            d_resp_o    = mem_resp_i || w_tmo;
            if (w_done) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // Keep the port quiet while reset is held, whatever the state register holds.
      if (rst_i) begin
         mem_read_o  = 1'b0;
         mem_write_o = 1'b0;
         i_resp_o    = 1'b0;
         d_resp_o    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         r_state  <= IDLE;
         r_last_d <= 1'b0;
         r_cnt    <= '0;
         r_err    <= 1'b0;
      end else begin
         r_state <= w_next;
         if (r_state == IDLE)                     r_cnt <= '0;
         else if (!mem_resp_i && (r_cnt != '1))   r_cnt <= r_cnt + CW'(1);
         if (w_done) r_last_d <= (r_state == GNT_D);
         if (w_tmo)  r_err    <= 1'b1;
      end
   end

endmodule

// File: tb/tb_rvga_membus_arbiter.sv
// Self-checking bench for rvga_membus_arbiter: directed scenarios plus
// randomized traffic against a transaction-level round-robin model.
module tb_rvga_membus_arbiter;

   localparam int TO = 4;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic [31:0] i_addr_i, d_addr_i, d_wdata_i, mem_rdata_i;
   logic        i_read_i, d_read_i, d_write_i, mem_resp_i;
   logic [31:0] i_rdata_o, d_rdata_o, mem_addr_o, mem_wdata_o;
   logic        i_resp_o, d_resp_o, mem_read_o, mem_write_o, timeout_err_o;

   int n_chk  = 0;
   int n_pass = 0;

   // reference model state: who was served last, sticky timeout flag
   bit m_last_d;
   bit m_err;

   rvga_membus_arbiter #(.addr_width(32), .data_width(32), .timeout_cycles(TO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .i_addr_i(i_addr_i), .i_read_i(i_read_i), .i_rdata_o(i_rdata_o), .i_resp_o(i_resp_o),
      .d_addr_i(d_addr_i), .d_read_i(d_read_i), .d_write_i(d_write_i), .d_wdata_i(d_wdata_i),
      .d_rdata_o(d_rdata_o), .d_resp_o(d_resp_o),
      .mem_addr_o(mem_addr_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
      .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_resp_i(mem_resp_i),
      .timeout_err_o(timeout_err_o)
   );

   always #5 clk_i = ~clk_i;

   // Memory-side driver: waits for a strobe, responds in GNT cycle 'lat'
   // (0 = never) and reports what it saw. Called just after a negedge.
   task automatic serve(input int lat, input logic [31:0] rdat,
                        output int gap, output logic [31:0] a, output logic r, output logic w,
                        output logic [31:0] wd, output logic ri, output logic rdv,
                        output logic [31:0] rdi, output logic [31:0] rdd,
                        output int sc, output int gcyc);
      gap = 0; sc = 0; gcyc = -1; a = '0; r = 0; w = 0; wd = '0;
      ri = 0; rdv = 0; rdi = '0; rdd = '0;
      #1;
      while (!(mem_read_o || mem_write_o) && gap < 20) begin
         @(negedge clk_i); #1; gap++;
      end
      if (!(mem_read_o || mem_write_o)) return;
      a = mem_addr_o; r = mem_read_o; w = mem_write_o; wd = mem_wdata_o;
      for (int c = 1; c <= 12; c++) begin
         if (c == lat) begin mem_resp_i = 1'b1; mem_rdata_i = rdat; #1; end
         if (mem_read_o || mem_write_o) sc++;
         if (i_resp_o || d_resp_o) begin
            ri = i_resp_o; rdv = d_resp_o; rdi = i_rdata_o; rdd = d_rdata_o; gcyc = c;
            return;
         end
         @(negedge clk_i); #1;
      end
   endtask

   task automatic test_reset();
      int gap, sc, gc; logic [31:0] a, wd, rdi, rdd; logic r, w, ri, rdv;
      rst_i = 1; i_read_i = 1; d_read_i = 1; d_write_i = 0; mem_resp_i = 0;
      i_addr_i = 32'h1111_0000; d_addr_i = 32'h2222_0000; d_wdata_i = 0; mem_rdata_i = 0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk_i); #1;
         n_chk++;
         if ({mem_read_o, mem_write_o, i_resp_o, d_resp_o, timeout_err_o} !== 5'b0)
            $display("FAIL reset_outs cyc%0d: got %b want 00000", k,
                     {mem_read_o, mem_write_o, i_resp_o, d_resp_o, timeout_err_o});
         else n_pass++;
      end
      @(negedge clk_i); rst_i = 0; m_last_d = 0; m_err = 0;
      serve(1, 32'hA5A5_0001, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
      n_chk++;
      if (!(a === d_addr_i && rdv === 1'b1 && ri === 1'b0 && gap == 1))
         $display("FAIL reset_first_grant: addr=%h dresp=%b iresp=%b gap=%0d want addr=%h D-only gap=1",
                  a, rdv, ri, gap, d_addr_i);
      else n_pass++;
      m_last_d = 1;
      @(negedge clk_i); mem_resp_i = 0; i_read_i = 0; d_read_i = 0; #1;
      n_chk++;
      if ({mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o} !== 66'b0)
         $display("FAIL idle_outs: rd=%b wr=%b addr=%h wd=%h want all 0",
                  mem_read_o, mem_write_o, mem_addr_o, mem_wdata_o);
      else n_pass++;
   endtask

   task automatic test_single_i_read();
      int gap, sc, gc; logic [31:0] a, wd, rdi, rdd; logic r, w, ri, rdv;
      @(negedge clk_i); i_addr_i = 32'h100; i_read_i = 1;
      serve(3, 32'hDEAD_BEEF, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
      n_chk++;
      if (!(sc == 3 && a === 32'h100 && r === 1'b1 && w === 1'b0))
         $display("FAIL i_read_strobe: cycles=%0d addr=%h rd=%b wr=%b want 3 100 1 0", sc, a, r, w);
      else n_pass++;
      n_chk++;
      if (!(ri === 1'b1 && rdv === 1'b0 && rdi === 32'hDEAD_BEEF))
         $display("FAIL i_read_resp: iresp=%b dresp=%b rdata=%h want 1 0 deadbeef", ri, rdv, rdi);
      else n_pass++;
      m_last_d = 0;
      @(negedge clk_i); mem_resp_i = 0; i_read_i = 0;
   endtask

   task automatic test_d_write();
      int gap, sc, gc; logic [31:0] a, wd, rdi, rdd; logic r, w, ri, rdv;
      @(negedge clk_i); d_addr_i = 32'h200; d_wdata_i = 32'h1234_5678; d_read_i = 1; d_write_i = 1;
      serve(2, 32'h0, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
      n_chk++;
      if (!(w === 1'b1 && r === 1'b0 && wd === 32'h1234_5678 && a === 32'h200))
         $display("FAIL d_write_strobe: wr=%b rd=%b wd=%h addr=%h want 1 0 12345678 200", w, r, wd, a);
      else n_pass++;
      n_chk++;
      if (!(rdv === 1'b1 && ri === 1'b0 && gc == 2))
         $display("FAIL d_write_resp: dresp=%b iresp=%b cyc=%0d want 1 0 2", rdv, ri, gc);
      else n_pass++;
      m_last_d = 1;
      @(negedge clk_i); mem_resp_i = 0; d_read_i = 0; d_write_i = 0;
   endtask

   task automatic test_contention();
      int gap, sc, gc; logic [31:0] a, wd, rdi, rdd; logic r, w, ri, rdv;
      bit exp_d;
      @(negedge clk_i); i_addr_i = 32'h1000; d_addr_i = 32'h2000; i_read_i = 1; d_read_i = 1;
      for (int t = 0; t < 6; t++) begin
         exp_d = !m_last_d;
         serve(1, 32'hC0DE_0000 + t, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
         n_chk++;
         if (!(a === (exp_d ? 32'h2000 : 32'h1000) && rdv === exp_d && ri === !exp_d && gap == 1))
            $display("FAIL contention_t%0d: addr=%h iresp=%b dresp=%b gap=%0d want %s gap=1",
                     t, a, ri, rdv, gap, exp_d ? "D" : "I");
         else n_pass++;
         m_last_d = exp_d;
         @(negedge clk_i); mem_resp_i = 0;
      end
      i_read_i = 0; d_read_i = 0;
   endtask

   task automatic test_random();
      int gap, sc, gc, lat; logic [31:0] a, wd, rdi, rdd, dat; logic r, w, ri, rdv;
      bit pi, pd, exp_d;
      pi = 0; pd = 0;
      @(negedge clk_i);
      for (int t = 0; t < 40; t++) begin
         if (!pi && $urandom_range(1, 0)) begin
            pi = 1; i_read_i = 1; i_addr_i = $urandom;
         end
         if (!pd && ($urandom_range(1, 0) || !pi)) begin
            pd = 1; d_addr_i = $urandom; d_wdata_i = $urandom;
            d_read_i = $urandom_range(1, 0); d_write_i = $urandom_range(1, 0);
            if (!d_read_i && !d_write_i) d_read_i = 1;
         end
         exp_d = (pi && pd) ? !m_last_d : pd;
         lat = $urandom_range(TO + 1, 1);
         dat = $urandom;
         serve(lat, dat, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
         n_chk++;
         if (!(rdv === exp_d && ri === !exp_d && gc == lat && sc == lat && gap == 1 &&
               a === (exp_d ? d_addr_i : i_addr_i) &&
               w === (exp_d && d_write_i) && r === !(exp_d && d_write_i) &&
               (!exp_d || !d_write_i || wd === d_wdata_i) &&
               rdi === dat && rdd === dat))
            $display("FAIL random_t%0d: iresp=%b dresp=%b cyc=%0d sc=%0d gap=%0d addr=%h rd=%b wr=%b want %s lat=%0d",
                     t, ri, rdv, gc, sc, gap, a, r, w, exp_d ? "D" : "I", lat);
         else n_pass++;
         m_last_d = exp_d;
         @(negedge clk_i); mem_resp_i = 0;
         if (exp_d) begin pd = 0; d_read_i = 0; d_write_i = 0; end
         else begin pi = 0; i_read_i = 0; end
      end
      i_read_i = 0; d_read_i = 0; d_write_i = 0;
      #1;
      n_chk++;
      if (timeout_err_o !== m_err)
         $display("FAIL no_spurious_timeout: err=%b want %b", timeout_err_o, m_err);
      else n_pass++;
   endtask

   task automatic test_timeout();
      int gap, sc, gc; logic [31:0] a, wd, rdi, rdd; logic r, w, ri, rdv;
      @(negedge clk_i); d_addr_i = 32'h300; d_read_i = 1; d_write_i = 0;
      serve(0, 32'h0, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
      n_chk++;
      if (!(rdv === 1'b1 && ri === 1'b0 && gc == TO + 1))
         $display("FAIL timeout_resp: dresp=%b iresp=%b cyc=%0d want 1 0 %0d", rdv, ri, gc, TO + 1);
      else n_pass++;
      m_last_d = 1; m_err = 1;
      @(negedge clk_i); d_read_i = 0; i_addr_i = 32'h400; i_read_i = 1; #1;
      n_chk++;
      if (timeout_err_o !== m_err) $display("FAIL timeout_flag: err=%b want 1", timeout_err_o);
      else n_pass++;
      serve(2, 32'hFEED_F00D, gap, a, r, w, wd, ri, rdv, rdi, rdd, sc, gc);
      n_chk++;
      if (!(ri === 1'b1 && rdv === 1'b0 && a === 32'h400 && gc == 2 && rdi === 32'hFEED_F00D &&
            timeout_err_o === 1'b1))
         $display("FAIL timeout_next_i: iresp=%b dresp=%b addr=%h cyc=%0d err=%b want 1 0 400 2 1",
                  ri, rdv, a, gc, timeout_err_o);
      else n_pass++;
      m_last_d = 0;
      @(negedge clk_i); mem_resp_i = 0; i_read_i = 0;
   endtask

   task automatic test_reset_mid();
      @(negedge clk_i); i_addr_i = 32'h500; i_read_i = 1;
      @(negedge clk_i); #1;
      n_chk++;
      if (mem_read_o !== 1'b1 || mem_addr_o !== 32'h500)
         $display("FAIL mid_grant: rd=%b addr=%h want 1 500", mem_read_o, mem_addr_o);
      else n_pass++;
      rst_i = 1; i_read_i = 0;
      @(negedge clk_i); rst_i = 0; mem_resp_i = 1; mem_rdata_i = 32'h5555_AAAA;
      for (int k = 0; k < 2; k++) begin
         #1;
         n_chk++;
         if ({mem_read_o, mem_write_o, i_resp_o, d_resp_o, timeout_err_o} !== 5'b0)
            $display("FAIL mid_reset_cyc%0d: rd/wr/iresp/dresp/err=%b want 00000", k,
                     {mem_read_o, mem_write_o, i_resp_o, d_resp_o, timeout_err_o});
         else n_pass++;
         @(negedge clk_i);
      end
      mem_resp_i = 0;
   endtask

   initial begin
      test_reset();
      test_single_i_read();
      test_d_write();
      test_contention();
      test_random();
      test_timeout();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
